// File: rtl/ps2_rx_decoder_if.sv
// PS/2 receiver bus: raw pin inputs plus the decoded byte, status pulses,
// two-byte history and busy flag. The bench drives it through the master
// modport and the decoder uses the slave modport.
interface ps2_rx_decoder_if;
    logic        ps2_clk;
    logic        ps2_dat;
    logic [7:0]  byte_o;
    logic        byte_valid;
    logic        parity_err;
    logic        frame_err;
    logic [15:0] history;
    logic        busy;

    modport master (
        output ps2_clk,
        output ps2_dat,
        input  byte_o,
        input  byte_valid,
        input  parity_err,
        input  frame_err,
        input  history,
        input  busy
    );

    modport slave (
        input  ps2_clk,
        input  ps2_dat,
        output byte_o,
        output byte_valid,
        output parity_err,
        output frame_err,
        output history,
        output busy
    );
endinterface

// File: rtl/ps2_rx_decoder.sv
// PS/2 device-to-host frame receiver.
// Pins are synchronized, the PS/2 clock is glitch filtered, and each filtered
// falling edge clocks one bit into a small frame FSM (start, 8 data LSB first,
// odd parity, stop). Good frames update byte_o and a two-byte history; bad
// parity, bad stop bits and inter-edge timeouts raise single-cycle error pulses.
module ps2_rx_decoder #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic            clk_clk,
    input  logic            reset_reset_n,
    ps2_rx_decoder_if.slave bus
);

    localparam int FCNT_W = $clog2(FILTER_LEN + 1);
    localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Odd parity over eight data bits plus the parity bit: 1 means correct.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    // Pin synchronizers (bit 0 is the first stage).
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;

    // Glitch filter and edge detect.
    logic              filt_q, filt_d;
    logic [FCNT_W-1:0] filt_cnt_q, filt_cnt_d;
    logic              filt_dly_q, filt_dly_d;
    logic              fall_q, fall_d;
    logic              bit_q, bit_d;

    // Frame FSM and datapath.
    state_t            state_q, state_d;
    logic [2:0]        bitcnt_q, bitcnt_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              par_ok_q, par_ok_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [WD_W-1:0]   wd_inc_s;
    logic              timeout_s;
    logic [7:0]        byte_q, byte_d;
    logic [15:0]       hist_q, hist_d;
    logic              byte_valid_q, byte_valid_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d;
    logic              busy_q, busy_d;

    // Shift both raw pins into their synchronizer chains.
    always_comb begin
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], bus.ps2_clk};
        dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], bus.ps2_dat};
    end

    // Filter the synchronized clock, detect its falling edge and capture data with it.
    always_comb begin
        if (clk_sync_q[SYNC_STAGES-1] != filt_q) begin
            if (filt_cnt_q == FCNT_W'(FILTER_LEN - 1)) begin
                filt_d     = clk_sync_q[SYNC_STAGES-1];
                filt_cnt_d = '0;
            end else begin
                filt_d     = filt_q;
                filt_cnt_d = filt_cnt_q + FCNT_W'(1);
            end
        end else begin
            filt_d     = filt_q;
            filt_cnt_d = '0;
        end

        filt_dly_d = filt_q;
        // One cycle after the filtered level drops, so the pulse is registered.
        fall_d     = filt_dly_q & ~filt_q;

        if (fall_d) begin
            bit_d = dat_sync_q[SYNC_STAGES-1];
        end else begin
            bit_d = bit_q;
        end
    end

    // Front-end registers; idle bus level is high so everything resets to 1.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
            filt_dly_q <= 1'b1;
            fall_q     <= 1'b0;
            bit_q      <= 1'b1;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
            filt_dly_q <= filt_dly_d;
            fall_q     <= fall_d;
            bit_q      <= bit_d;
        end
    end

    // Frame FSM next state, watchdog and output pulse generation.
    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        shreg_d      = shreg_q;
        par_ok_d     = par_ok_q;
        wd_d         = wd_q;
        byte_d       = byte_q;
        hist_d       = hist_q;
        byte_valid_d = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;

        // Abort on the edge where the counter would reach TIMEOUT_CYCLES-1, so
        // frame_err lands exactly TIMEOUT_CYCLES cycles after the last fall.
        wd_inc_s  = wd_q + WD_W'(1);
        timeout_s = (state_q != ST_IDLE) && (wd_inc_s == WD_W'(TIMEOUT_CYCLES - 1));

        if (fall_q) begin
            // A real edge always beats a coincident timeout.
            wd_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (!bit_q) begin
                        state_d  = ST_DATA;
                        bitcnt_d = 3'd0;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    shreg_d  = {bit_q, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_PARITY: begin
                    par_ok_d = odd_parity_ok(shreg_q, bit_q);
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    if (!bit_q) begin
                        frame_err_d  = 1'b1;
                    end else if (par_ok_q) begin
                        byte_d       = shreg_q;
                        hist_d       = {hist_q[7:0], shreg_q};
                        byte_valid_d = 1'b1;
                    end else begin
                        parity_err_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (timeout_s) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
            shreg_d     = 8'h00;
            bitcnt_d    = 3'd0;
            wd_d        = '0;
        end else if (state_q != ST_IDLE) begin
            wd_d = wd_inc_s;
        end else begin
            wd_d = '0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // Frame FSM state, datapath and registered outputs.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q      <= ST_IDLE;
            bitcnt_q     <= 3'd0;
            shreg_q      <= 8'h00;
            par_ok_q     <= 1'b0;
            wd_q         <= '0;
            byte_q       <= 8'h00;
            hist_q       <= 16'h0000;
            byte_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            shreg_q      <= shreg_d;
            par_ok_q     <= par_ok_d;
            wd_q         <= wd_d;
            byte_q       <= byte_d;
            hist_q       <= hist_d;
            byte_valid_q <= byte_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.byte_o     = byte_q;
    assign bus.history    = hist_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.parity_err = parity_err_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = busy_q;

endmodule

// File: doc/ps2_rx_decoder.md
# ps2_rx_decoder

Receives device-to-host PS/2 frames from raw keyboard clock/data pins, validates them, and emits one scan-code byte per good frame. Also keeps a 16-bit history of the last two received bytes. It sits directly downstream of the PS/2 pins and upstream of the four-digit hex display, which shows `history[15:0]` (nibbles 15:12 down to 3:0 on HEX0..HEX3).

## Interface
- `SYNC_STAGES`, default 2: flops in each pin synchronizer (≥2).
- `FILTER_LEN`, default 4: consecutive equal synchronized samples required before the filtered PS/2 clock changes level.
- `TIMEOUT_CYCLES`, default 50000: system cycles allowed between PS/2 clock falling edges inside a frame (1 ms at 50 MHz).
- `clk_clk` input 1: system clock, 50 MHz, rising-edge.
- `reset_reset_n` input 1: asynchronous, active-low reset.
- `ps2_clk` input 1: raw PS/2 clock pin, asynchronous to `clk_clk`.
- `ps2_dat` input 1: raw PS/2 data pin, asynchronous to `clk_clk`.
- `byte_o` output 8: last good byte; holds until the next good frame.
- `byte_valid` output 1: one-cycle pulse when `byte_o` updates.
- `parity_err` output 1: one-cycle pulse on a parity failure.
- `frame_err` output 1: one-cycle pulse on a bad stop bit or a timeout.
- `history` output 16: `{previous byte, latest byte}`.
- `busy` output 1: high while a frame is in progress (state ≠ IDLE).

## Operation
- Both pins pass through `SYNC_STAGES` flops.
- Glitch filter on the synchronized clock: the filtered level changes only after `FILTER_LEN` consecutive samples at the new level. Filtered clock and data-sample registers reset to 1.
- `fall` is a registered one-cycle pulse raised when the filtered clock goes 1→0. The synchronized data bit is captured in that same cycle.
- Frame format: start bit 0, then 8 data bits LSB first, then odd parity, then stop bit 1.
- FSM states and transitions:
  - IDLE: on `fall` with data 0, go to DATA and clear `bitcnt`. On `fall` with data 1, stay in IDLE (spurious edge, no error).
  - DATA: on `fall`, shift right with the new bit entering `shreg[7]`. After the 8th bit, go to PARITY.
  - PARITY: on `fall`, set `par_ok = ^{shreg, bit}` (odd parity, so `par_ok` = 1 means correct). Go to STOP.
  - STOP: on `fall`:
    - stop bit 1 and `par_ok`: `byte_o` ← `shreg`, `history` ← `{history[7:0], shreg}`, pulse `byte_valid`.
    - stop bit 1 and not `par_ok`: pulse `parity_err`.
    - stop bit 0: pulse `frame_err` (takes priority over `parity_err`).
    - In every case go to IDLE.
- Watchdog: a counter runs in every state except IDLE and clears on each `fall`. When it reaches `TIMEOUT_CYCLES-1`, the FSM returns to IDLE, `frame_err` pulses, and the partial byte is discarded.
- If `fall` and the timeout occur in the same cycle, `fall` wins.
- Error frames never modify `byte_o` or `history`.
- Reset values: state IDLE; `byte_o`, `history`, `bitcnt`, `shreg` and the watchdog counter all 0; `byte_valid`, `parity_err`, `frame_err` and `busy` all 0.
- Reset asserted mid-frame aborts the frame immediately with no error pulse.

## Timing
- Edge detection latency: `SYNC_STAGES + FILTER_LEN + 1` cycles from the pin falling to the `fall` pulse.
- `byte_valid`, `byte_o` and `history` update on the clock edge after the `fall` that samples the stop bit. `byte_o` and `history` are stable in the cycle `byte_valid` is high.
- `byte_valid`, `parity_err` and `frame_err` are single-cycle pulses and are mutually exclusive.
- `busy` rises the cycle after the start-bit `fall` and drops the cycle after the stop-bit `fall` or the timeout.
- Minimum supported PS/2 half-period: `FILTER_LEN + 2` system cycles. Real devices (10–16.7 kHz) are far slower.
- Back-to-back frames need no idle gap beyond the stop bit.

## Test plan
- Good frame: send 0x1C (start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1) at 12.5 kHz. Expect exactly one `byte_valid`, `byte_o` = 0x1C, `history` = 0x001C, no error pulses.
- Break sequence: send 0xF0 (parity 1), then 0x1C. Expect two `byte_valid` pulses and `history` = 0xF01C.
- Bad parity: send 0x1C with parity bit 1. Expect one `parity_err`, no `byte_valid`, `history` unchanged, then a following good 0x32 is accepted.
- Bad stop: send 0x1C with stop bit 0. Expect `frame_err` only, no `byte_valid`.
- Timeout and glitch:
  - 2-cycle low glitch on `ps2_clk` in IDLE: expect no state change.
  - Stop clocking after 4 data bits: expect `frame_err` exactly `TIMEOUT_CYCLES` cycles after the last `fall`, and `busy` to drop.
- Reset mid-frame: pull `reset_reset_n` low after bit 5. Expect all outputs 0 asynchronously and no error pulse; after release, a full 0x1C frame decodes correctly.
